// File: rtl/video_st_packetizer_if.sv
// Pixel-word input and Avalon-ST source bundle for video_st_packetizer.
// master: the packetizer's view; slave: the decoder/downstream environment's view.
interface video_st_packetizer_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] pix_data;
    logic              pix_sof;
    logic              pix_valid;
    logic              pix_ready;
    logic [DATA_W-1:0] avalonst_source_data;
    logic [1:0]        avalonst_source_empty;
    logic              avalonst_source_startofpacket;
    logic              avalonst_source_endofpacket;
    logic              avalonst_source_valid;
    logic              avalonst_source_ready;

    modport master (
        input  pix_data, pix_sof, pix_valid,
        output pix_ready,
        output avalonst_source_data, avalonst_source_empty,
        output avalonst_source_startofpacket, avalonst_source_endofpacket,
        output avalonst_source_valid,
        input  avalonst_source_ready
    );

    modport slave (
        output pix_data, pix_sof, pix_valid,
        input  pix_ready,
        input  avalonst_source_data, avalonst_source_empty,
        input  avalonst_source_startofpacket, avalonst_source_endofpacket,
        input  avalonst_source_valid,
        output avalonst_source_ready
    );
endinterface

// File: rtl/video_st_packetizer.sv
// Frames decoder pixel words into one Avalon-ST packet per frame, padding frames cut short by an early SOF.
// Latency 1 clk into an empty skid buffer; optional header beat with VIDEO_ST_PACKETIZER_HDR_EN.
// Backpressure: 2-entry skid buffer, registered pix_ready drops when 2 entries are held or while padding.
module video_st_packetizer #(
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 320,
    parameter int LINES      = 240,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    video_st_packetizer_if.master vid,
    output logic [CNT_W-1:0]     frame_cnt,
    output logic [CNT_W-1:0]     err_cnt
);
    localparam int XW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int YW = (LINES > 1) ? $clog2(LINES) : 1;
    localparam logic [XW-1:0]    X_LAST = XW'(LINE_WORDS - 1);
    localparam logic [YW-1:0]    Y_LAST = YW'(LINES - 1);
    localparam logic [XW-1:0]    X_ONE  = XW'(1);
    localparam logic [YW-1:0]    Y_ONE  = YW'(1);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    typedef struct packed {
        logic              sop;
        logic              eop;
        logic [DATA_W-1:0] data;
    } beat_t;

    typedef enum logic [2:0] {S_IDLE, S_ACTIVE, S_PAD, S_RESUME, S_HDR} state_t;

    state_t            state_q, state_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              orphan_q, orphan_d;
    beat_t             ent0_q, ent1_q, push_beat;
    logic [1:0]        count_q, count_d;
    logic              rdy_q, rdy_d;
    logic              accept, pop, space, push, start, advance;
    logic              last, line_end, frame_inc, err_inc, wr_lo;

    assign accept   = vid.pix_valid & rdy_q;
    assign pop      = (count_q != 2'd0) & vid.avalonst_source_ready;
    assign space    = (count_q != 2'd2) | pop;
    assign line_end = (x_q == X_LAST);
    assign last     = line_end & (y_q == Y_LAST);

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        hold_d    = hold_q;
        orphan_d  = orphan_q;
        push      = 1'b0;
        push_beat = '0;
        start     = 1'b0;
        advance   = 1'b0;
        frame_inc = 1'b0;
        err_inc   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept && vid.pix_sof) begin
                    start    = 1'b1;
                    hold_d   = vid.pix_data;
                    orphan_d = 1'b0;
                end else if (accept && !orphan_q) begin
                    err_inc  = 1'b1;
                    orphan_d = 1'b1;
                end
            end
            S_ACTIVE: begin
                if (accept && vid.pix_sof && (x_q != '0 || y_q != '0)) begin
                    hold_d  = vid.pix_data;
                    err_inc = 1'b1;
                    state_d = S_PAD;
                end else if (accept) begin
                    push           = 1'b1;
                    push_beat.eop  = last;
                    push_beat.data = vid.pix_data;
                    advance        = 1'b1;
                end
            end
            S_PAD: begin
                if (space) begin
                    push          = 1'b1;
                    push_beat.eop = last;
                    advance       = 1'b1;
                end
            end
            S_RESUME: begin
                start = space;
            end
`ifdef VIDEO_ST_PACKETIZER_HDR_EN
            S_HDR: begin
                if (space) begin
                    push           = 1'b1;
                    push_beat.data = hold_q;
                    x_d            = X_ONE;
                    y_d            = '0;
                    state_d        = S_ACTIVE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // Frame start: the SOF word is the live input in IDLE or the held word after padding.
        if (start) begin
            push          = 1'b1;
            push_beat.sop = 1'b1;
`ifdef VIDEO_ST_PACKETIZER_HDR_EN
            state_d       = S_HDR;
`else
            push_beat.data = hold_d;
            x_d            = X_ONE;
            y_d            = '0;
            state_d        = S_ACTIVE;
`endif
        end

        if (advance) begin
            if (last) begin
                x_d       = '0;
                y_d       = '0;
                frame_inc = 1'b1;
                state_d   = (state_q == S_PAD) ? S_RESUME : S_IDLE;
            end else if (line_end) begin
                x_d = '0;
                y_d = y_q + Y_ONE;
            end else begin
                x_d = x_q + X_ONE;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop)      count_d = count_q + 2'd1;
        else if (!push && pop) count_d = count_q - 2'd1;
        rdy_d = (count_d != 2'd2) && (state_d == S_IDLE || state_d == S_ACTIVE);
        wr_lo = (count_q == 2'd0) || (count_q == 2'd1 && pop);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            hold_q    <= '0;
            orphan_q  <= 1'b0;
            ent0_q    <= '0;
            ent1_q    <= '0;
            count_q   <= '0;
            rdy_q     <= 1'b0;
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            hold_q   <= hold_d;
            orphan_q <= orphan_d;
            count_q  <= count_d;
            rdy_q    <= rdy_d;
            if (pop) ent0_q <= ent1_q;
            if (push && wr_lo) ent0_q <= push_beat;
            if (push && !wr_lo) ent1_q <= push_beat;
            if (frame_inc) frame_cnt <= frame_cnt + C_ONE;
            if (err_inc && err_cnt != '1) err_cnt <= err_cnt + C_ONE;
        end
    end

    assign vid.pix_ready                     = rdy_q;
    assign vid.avalonst_source_valid         = (count_q != 2'd0);
    assign vid.avalonst_source_data          = ent0_q.data;
    assign vid.avalonst_source_startofpacket = ent0_q.sop;
    assign vid.avalonst_source_endofpacket   = ent0_q.eop;
    assign vid.avalonst_source_empty         = 2'b00;
endmodule

// File: tb/tb_video_st_packetizer.sv
// Scoreboard bench for video_st_packetizer (4 words x 2 lines): frame-position reference model feeds an
// expected-beat queue; an independent monitor pops and compares every transferred beat.
module tb_video_st_packetizer;
    localparam int DW = 32, LW = 4, NL = 2, CW = 16, FRAME = LW * NL;
`ifdef VIDEO_ST_PACKETIZER_HDR_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    typedef struct packed {
        logic          sop;
        logic          eop;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [CW-1:0] frame_cnt, err_cnt;
    always #5 clk = ~clk;

    video_st_packetizer_if #(.DATA_W(DW)) vid();

    video_st_packetizer #(.DATA_W(DW), .LINE_WORDS(LW), .LINES(NL), .CNT_W(CW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .vid      (vid),
        .frame_cnt(frame_cnt),
        .err_cnt  (err_cnt)
    );

    exp_t exp_q[$];
    int   n_chk = 0, n_fail = 0;
    int   cyc = 0, acc_cyc = 0, sop_cyc = -1;
    int   rdy_mode = 0, rdy_phase = 0;
    bit   pr_low = 0;
    // reference model: position within the frame, not line/word counters
    bit   m_active = 0, m_orphan = 0;
    int   m_pos = 0, m_frames = 0, m_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic s, input logic e, input logic [DW-1:0] d);
        exp_t b;
        b.sop = s; b.eop = e; b.data = d;
        return b;
    endfunction

    task automatic model_start(input logic [DW-1:0] d);
        if (HDR != 0) begin
            exp_q.push_back(mk(1'b1, 1'b0, '0));
            exp_q.push_back(mk(1'b0, 1'b0, d));
        end else begin
            exp_q.push_back(mk(1'b1, 1'b0, d));
        end
        m_pos = 1;
        m_active = 1;
    endtask

    task automatic model_accept(input logic [DW-1:0] d, input logic sof);
        if (!m_active) begin
            if (sof) begin
                m_orphan = 0;
                model_start(d);
            end else if (!m_orphan) begin
                m_orphan = 1;
                m_err++;
            end
        end else if (sof) begin
            for (int p = m_pos; p < FRAME; p++) exp_q.push_back(mk(1'b0, p == FRAME - 1, '0));
            m_frames++;
            m_err++;
            model_start(d);
        end else begin
            exp_q.push_back(mk(1'b0, m_pos == FRAME - 1, d));
            m_pos++;
            if (m_pos == FRAME) begin
                m_active = 0;
                m_frames++;
            end
        end
    endtask

    task automatic send_word(input logic [DW-1:0] d, input logic sof);
        vid.pix_data  = d;
        vid.pix_sof   = sof;
        vid.pix_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (vid.pix_ready) begin
                model_accept(d, sof);
                acc_cyc = cyc;
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
        n_chk++;
        n_fail++;
        $display("FAIL send_accept: word 0x%0h not accepted, pix_ready stuck at %0b", d, vid.pix_ready);
    endtask

    task automatic idle(input int n);
        vid.pix_valid = 1'b0;
        vid.pix_sof   = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_frame(input logic [DW-1:0] base);
        for (int i = 0; i < FRAME; i++) send_word(base + DW'(i), i == 0);
        idle(0);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 600 && (exp_q.size() != 0 || vid.avalonst_source_valid); i++) @(negedge clk);
        @(posedge clk); #1;
        chk({tag, "_beats_left"}, exp_q.size(), 0);
        chk({tag, "_frame_cnt"}, frame_cnt, CW'(m_frames));
        chk({tag, "_err_cnt"}, err_cnt, CW'(m_err));
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_active = 0; m_orphan = 0; m_pos = 0; m_frames = 0; m_err = 0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctrl"}, {vid.avalonst_source_valid, vid.avalonst_source_startofpacket,
                             vid.avalonst_source_endofpacket, vid.avalonst_source_empty, vid.pix_ready}, 0);
        chk({tag, "_data"}, vid.avalonst_source_data, 0);
        chk({tag, "_counters"}, {frame_cnt, err_cnt}, 0);
    endtask

    // downstream ready generator
    initial begin
        vid.avalonst_source_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0: vid.avalonst_source_ready = 1'b1;
                1: begin
                    vid.avalonst_source_ready = (rdy_phase % 4 == 0) || (rdy_phase % 4 == 3);
                    rdy_phase++;
                end
                2: vid.avalonst_source_ready = ($urandom_range(0, 2) != 0);
                default: vid.avalonst_source_ready = ($urandom_range(0, 1) != 0);
            endcase
        end
    end

    // monitor: compares each transferred beat against the scoreboard and checks stall stability
    initial begin
        exp_t cur, held, e;
        bit   stall;
        stall = 0;
        held  = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                stall = 0;
            end else begin
                if (!vid.pix_ready) pr_low = 1;
                if (vid.avalonst_source_valid) begin
                    cur = mk(vid.avalonst_source_startofpacket, vid.avalonst_source_endofpacket,
                             vid.avalonst_source_data);
                    if (stall) chk("stall_stable", cur, held);
                    if (cur.sop && !stall && sop_cyc < 0) sop_cyc = cyc;
                    if (vid.avalonst_source_ready) begin
                        chk("empty", vid.avalonst_source_empty, 0);
                        if (exp_q.size() == 0) begin
                            n_chk++;
                            n_fail++;
                            $display("FAIL beat_unexpected: got beat 0x%0h with empty scoreboard", cur);
                        end else begin
                            e = exp_q.pop_front();
                            chk("beat", cur, e);
                        end
                        stall = 0;
                    end else begin
                        stall = 1;
                        held  = cur;
                    end
                end else if (stall) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL valid_held: valid dropped to 0 while beat 0x%0h stalled", held);
                    stall = 0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        logic sof;
        reset_n       = 1'b1;
        vid.pix_data  = '0;
        vid.pix_sof   = 1'b0;
        vid.pix_valid = 1'b0;
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        reset_n = 1'b1;
        #2 chk("pix_ready_before_first_clk", vid.pix_ready, 0);
        @(posedge clk); #1;
        chk("pix_ready_after_release", vid.pix_ready, 1);

        // clean frame, ready held high: latency and sustained rate
        pr_low  = 0;
        sop_cyc = -1;
        send_word(32'h10, 1'b1);
        t0 = acc_cyc;
        for (int i = 1; i < FRAME; i++) send_word(32'h10 + DW'(i), 1'b0);
        idle(0);
        chk("sustained_accept_cycles", acc_cyc - t0, FRAME - 1 + HDR);
        drain("clean");
        chk("first_beat_latency", sop_cyc - t0, 1);
        chk("pix_ready_low_seen_clean", pr_low, HDR);

        // backpressure 1,0,0,1
        rdy_mode = 1;
        pr_low   = 0;
        send_frame(32'h20);
        drain("backpressure");
        chk("pix_ready_low_seen_bp", pr_low, 1);
        rdy_mode = 0;

        // orphans then clean frame
        for (int i = 0; i < 3; i++) send_word(32'hA1 + DW'(i), 1'b0);
        send_frame(32'h30);
        drain("orphans");

        // early SOF at word 5 of frame A
        for (int i = 0; i < 5; i++) send_word(32'h40 + DW'(i), i == 0);
        send_frame(32'h50);
        drain("early_sof");

        // asynchronous reset mid-frame after 3 words
        for (int i = 0; i < 3; i++) send_word(32'h60 + DW'(i), i == 0);
        #2;
        reset_n       = 1'b0;
        vid.pix_valid = 1'b0;
        vid.pix_sof   = 1'b0;
        #1;
        chk_zero("mid_reset");
        model_reset();
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        send_frame(32'h70);
        drain("after_reset");

        // randomized stream: random SOF placement, input gaps and downstream stalls
        for (int i = 0; i < 300; i++) begin
            rdy_mode = (i < 150) ? 2 : 3;
            sof = ($urandom_range(0, 5) == 0);
            send_word($urandom, sof);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        idle(0);
        drain("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
